seq_add_sub: RTL and testbench
==============================

Name: seq_add_sub

Overview:
Parametrised multi-cycle adder/subtractor, the next generation of the ALU's fixed 8-bit ripple adder. It processes a WIDTH-bit operand pair one SLICE-bit slice per clock, with carry held in a register between slices. It adds a subtract mode and status flags. It sits in the ALU datapath behind a valid/ready handshake, so wide operands never form a long combinational carry chain.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of SLICE.
SLICE, 8, bits processed per clock.
NSLICE, WIDTH/SLICE (derived, localparam), number of slice cycles per operation.

Ports:
iClk  input  1  clock; all state changes on the rising edge.
iRst_n  input  1  synchronous active-low reset, sampled on the iClk rising edge.
iValid  input  1  operand request valid.
oReady  output  1  block can accept a request.
iA  input  WIDTH  operand A.
iB  input  WIDTH  operand B.
iC  input  1  carry-in (add) / borrow-in (sub).
iSub  input  1  0 = add, 1 = subtract.
oValid  output  1  result valid.
iReady  input  1  downstream accepts result.
oSum  output  WIDTH  result.
oCarry  output  1  raw carry out of MSB.
oOverflow  output  1  signed two's-complement overflow.
oZero  output  1  oSum == 0.
oNeg  output  1  oSum[WIDTH-1].

Behaviour:
- Reset (iRst_n=0 at an edge): state=IDLE; oReady=1; oValid=0; oSum, oCarry, oOverflow, oZero, oNeg = 0.
- Reset mid-operation aborts the operation. The result is discarded and no oValid is produced.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - oReady=1.
  - On an edge with iValid=1, latch iA, iB, iSub and the effective carry, then go to RUN with slice index k=0.
  - Operand B is latched as iB when iSub=0, and as ~iB when iSub=1.
  - Effective carry is iC when iSub=0, and ~iC when iSub=1. Sub therefore computes A - B - iC.
- RUN:
  - oReady=0. iValid and all operand inputs are ignored.
  - Each edge adds slice k (bits k*SLICE .. k*SLICE+SLICE-1) of A and B plus the carry register.
  - The slice sum is written into the result register; the carry register takes the slice carry-out; k increments.
  - After the edge processing k=NSLICE-1, go to DONE.
- DONE:
  - oValid=1 and outputs are stable.
  - oCarry = final carry register. In sub mode, oCarry=1 means no borrow.
  - oOverflow = (A[MSB] == B'[MSB]) && (oSum[MSB] != A[MSB]), where B' is the latched (possibly inverted) operand.
  - oZero and oNeg are derived from the final oSum.
  - On an edge with iReady=1, go to IDLE. Outputs hold their values until the next completion.
- Latency:
  - Request accepted at edge T; oValid=1 in the cycle following edge T+NSLICE.
  - Throughput is one operation per NSLICE+2 cycles minimum.
  - oReady is never high while oValid is high, so acceptance and delivery cannot coincide.
- Result backpressure: in DONE with iReady=0, the block holds indefinitely.
- Slice index k is a $clog2(NSLICE)-bit counter (minimum 1 bit). It never wraps within an operation.
- NSLICE=1 degenerates to a single RUN cycle. This is legal and must be supported.

Decomposition:
- Package seq_add_sub_pkg holds the state enum (IDLE, RUN, DONE) and the mode constants (MODE_ADD=0, MODE_SUB=1).
- Sub-module slice_adder: combinational SLICE-bit ripple full-adder chain with inputs iA[SLICE], iB[SLICE], iC and outputs oSum[SLICE], oCarry. It is instantiated once and time-multiplexed by the FSM.

Test Plan:
- Add, WIDTH=32, SLICE=8: A=0x0000_00FF, B=0x0000_0001, iC=0 -> oSum=0x0000_0100, oCarry=0, oZero=0; oValid exactly 4 cycles after acceptance edge.
- Add with carry: A=0xFFFF_FFFF, B=0, iC=1 -> oSum=0, oCarry=1, oZero=1, oOverflow=0.
- Sub overflow: iSub=1, A=0x8000_0000, B=1, iC=0 -> oSum=0x7FFF_FFFF, oCarry=1, oOverflow=1, oNeg=0.
- Sub borrow: iSub=1, A=3, B=5, iC=1 -> oSum=0xFFFF_FFFD, oCarry=0, oNeg=1.
- Backpressure: hold iReady=0 for 10 cycles in DONE -> oValid and oSum stable, oReady=0; iValid pulses during RUN/DONE ignored; iReady=1 -> IDLE, oReady=1 next cycle.
- Reset mid-operation: assert iRst_n=0 during RUN slice 2 -> next cycle IDLE, all outputs 0, no oValid; a following request completes correctly.

Source files
------------

// File: rtl/seq_add_sub_pkg.sv
// Shared types and constants for the slice-serial adder/subtractor.
// Holds the controller state encoding, the mode values and the slice-index width helper.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Slice index needs at least one bit even when there is only one slice.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_add_sub_if.sv
// Request/result handshake bundle for seq_add_sub.
// The master side issues operands and accepts results; the slave side is the arithmetic block.
interface seq_add_sub_if #(
  parameter int WIDTH = 32
);
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             iC;
  logic             iSub;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oSum;
  logic             oCarry;
  logic             oOverflow;
  logic             oZero;
  logic             oNeg;

  modport master (
    output iValid, iA, iB, iC, iSub, iReady,
    input  oReady, oValid, oSum, oCarry, oOverflow, oZero, oNeg
  );

  modport slave (
    input  iValid, iA, iB, iC, iSub, iReady,
    output oReady, oValid, oSum, oCarry, oOverflow, oZero, oNeg
  );
endinterface

// File: rtl/seq_add_sub_slice_adder.sv
// Combinational SLICE-bit ripple-carry adder, time-multiplexed across the operand by seq_add_sub.
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] iA,
  input  logic [SLICE-1:0] iB,
  input  logic             iC,
  output logic [SLICE-1:0] oSum,
  output logic             oCarry
);

  logic [SLICE:0] carry;

  assign carry[0] = iC;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      assign oSum[gi]      = iA[gi] ^ iB[gi] ^ carry[gi];
      assign carry[gi + 1] = (iA[gi] & iB[gi]) | (carry[gi] & (iA[gi] ^ iB[gi]));
    end
  endgenerate

  assign oCarry = carry[SLICE];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: one SLICE-bit slice per clock with a registered carry,
// behind a valid/ready handshake, producing sum, carry, overflow, zero and negative flags.
module seq_add_sub
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  seq_add_sub_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = idx_width(NSLICE);

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             out_carry_reg;
  logic             ovf_reg;
  logic             zero_reg;
  logic             neg_reg;

  logic [SLICE-1:0] slice_sum;
  logic             slice_carry;
  logic [WIDTH-1:0] full_sum;
  logic             last_slice;
  logic             ready;
  logic             valid;

  // Operands shift right each slice, so the active slice is always the low bits.
  slice_adder #(.SLICE(SLICE)) u_slice (
    .iA     (a_reg[SLICE-1:0]),
    .iB     (b_reg[SLICE-1:0]),
    .iC     (carry_reg),
    .oSum   (slice_sum),
    .oCarry (slice_carry)
  );

  // Result fills from the top; after the last slice it holds the whole word.
  generate
    if (NSLICE == 1) begin : g_one
      assign full_sum = slice_sum;
    end else begin : g_many
      assign full_sum = {slice_sum, res_reg[WIDTH-1:SLICE]};
    end
  endgenerate

  assign last_slice = (k_reg == KW'(NSLICE - 1));

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    valid      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.iValid) state_next = RUN;
      end
      RUN: begin
        if (last_slice) state_next = DONE;
      end
      DONE: begin
        valid = 1'b1;
        if (bus.iReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      k_reg         <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      sum_reg       <= '0;
      out_carry_reg <= 1'b0;
      ovf_reg       <= 1'b0;
      zero_reg      <= 1'b0;
      neg_reg       <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.iValid) begin
        // Subtraction is A + ~B + ~borrow_in, i.e. A - B - iC.
        a_reg     <= bus.iA;
        b_reg     <= (bus.iSub == MODE_SUB) ? ~bus.iB : bus.iB;
        carry_reg <= (bus.iSub == MODE_SUB) ? ~bus.iC : bus.iC;
        k_reg     <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> SLICE;
        b_reg     <= b_reg >> SLICE;
        res_reg   <= full_sum;
        carry_reg <= slice_carry;
        if (!last_slice) begin
          k_reg <= k_reg + KW'(1);
        end else begin
          // The last slice carries the MSBs of A and B', so overflow is judged here.
          sum_reg       <= full_sum;
          out_carry_reg <= slice_carry;
          ovf_reg       <= (a_reg[SLICE-1] == b_reg[SLICE-1]) &&
                           (full_sum[WIDTH-1] != a_reg[SLICE-1]);
          zero_reg      <= (full_sum == '0);
          neg_reg       <= full_sum[WIDTH-1];
        end
      end
    end
  end

  assign bus.oReady    = ready;
  assign bus.oValid    = valid;
  assign bus.oSum      = sum_reg;
  assign bus.oCarry    = out_carry_reg;
  assign bus.oOverflow = ovf_reg;
  assign bus.oZero     = zero_reg;
  assign bus.oNeg      = neg_reg;

endmodule

// File: tb/tb_seq_add_sub.sv
// Self-checking bench for seq_add_sub: directed plan cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_seq_add_sub;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_add_sub_if #(.WIDTH(WIDTH)) bus ();

  seq_add_sub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as unsigned and signed values.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input logic sub, output logic [31:0] s, output logic co,
                       output logic ov, output logic z, output logic n);
    logic [32:0] wide;
    longint      sa, sb, cc, sres;
    sa = $signed(a);
    sb = $signed(b);
    cc = c;
    if (!sub) begin
      wide = {1'b0, a} + {1'b0, b} + {32'b0, c};
      co   = wide[32];
      sres = sa + sb + cc;
    end else begin
      wide = {1'b0, a} - {1'b0, b} - {32'b0, c};
      co   = ~wide[32];
      sres = sa - sb - cc;
    end
    s  = wide[31:0];
    ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    z  = (s == 32'd0);
    n  = s[31];
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic sub, input int hold);
    logic [31:0] es;
    logic        eco, eov, ez, en;
    int          cyc;
    model(a, b, c, sub, es, eco, eov, ez, en);
    @(negedge clk);
    check("ready_idle", bus.oReady, 1);
    bus.iValid = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    bus.iC     = c;
    bus.iSub   = sub;
    bus.iReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.iValid = 1'b0;
    cyc = 0;
    while (!bus.oValid && cyc < 20) begin
      check("ready_run", bus.oReady, 0);
      bus.iValid = 1'($urandom_range(0, 1));
      bus.iA     = $urandom;
      bus.iB     = $urandom;
      bus.iC     = 1'($urandom_range(0, 1));
      bus.iSub   = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, NSLICE);
    check("sum", bus.oSum, es);
    check("carry", bus.oCarry, eco);
    check("overflow", bus.oOverflow, eov);
    check("zero", bus.oZero, ez);
    check("neg", bus.oNeg, en);
    check("ready_done", bus.oReady, 0);
    for (int i = 0; i < hold; i++) begin
      bus.iValid = 1'($urandom_range(0, 1));
      bus.iA     = $urandom;
      @(negedge clk);
      check("valid_hold", bus.oValid, 1);
      check("sum_hold", bus.oSum, es);
      check("ready_hold", bus.oReady, 0);
    end
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.iReady = 1'b0;
    check("valid_clear", bus.oValid, 0);
    check("ready_back", bus.oReady, 1);
    check("sum_kept", bus.oSum, es);
    $display("op sub=%0d a=%08h b=%08h c=%0d -> sum=%08h carry=%0d ovf=%0d zero=%0d neg=%0d lat=%0d",
             sub, a, b, c, bus.oSum, bus.oCarry, bus.oOverflow, bus.oZero, bus.oNeg, cyc);
  endtask

  initial begin
    logic [31:0] ra, rb;
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iC     = 1'b0;
    bus.iSub   = 1'b0;
    bus.iReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.oReady, 1);
    check("rst_valid", bus.oValid, 0);
    check("rst_sum", bus.oSum, 0);
    check("rst_flags", {bus.oCarry, bus.oOverflow, bus.oZero, bus.oNeg}, 0);
    $display("reset ready=%0d valid=%0d sum=%08h", bus.oReady, bus.oValid, bus.oSum);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
    run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 10);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 2);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 0);

    // Abort in the middle of the third slice cycle.
    @(negedge clk);
    bus.iValid = 1'b1;
    bus.iA     = 32'hDEAD_BEEF;
    bus.iB     = 32'h0123_4567;
    bus.iC     = 1'b1;
    bus.iSub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", bus.oReady, 1);
    check("abort_valid", bus.oValid, 0);
    check("abort_sum", bus.oSum, 0);
    check("abort_flags", {bus.oCarry, bus.oOverflow, bus.oZero, bus.oNeg}, 0);
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(negedge clk);
      check("abort_no_valid", bus.oValid, 0);
    end
    $display("abort ready=%0d valid=%0d sum=%08h", bus.oReady, bus.oValid, bus.oSum);
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = 32'h8000_0000;
      if (i % 8 == 1) rb = 32'h8000_0000;
      if (i % 8 == 2) rb = ra;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
